// File: rtl/piso_shift_tx_if.sv
// Handshake and serial-output bundle for piso_shift_tx.
// master drives word/load/shift_en; slave (the transmitter) drives the rest.
//
// d_par      word to send            load_valid  d_par holds a word
// load_ready word accepted this cycle shift_en    advance one serial bit
// d_out      serial data             out_valid   d_out holds a data bit
// busy       word in flight          done        one-cycle end-of-word pulse
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d_par;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             d_out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output d_par,
        output load_valid,
        output shift_en,
        input  load_ready,
        input  d_out,
        input  out_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  d_par,
        input  load_valid,
        input  shift_en,
        output load_ready,
        output d_out,
        output out_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out shift transmitter with valid/ready word loading.
// Ports: clk, reset (async, active-low), bus (piso_shift_tx_if.slave):
//   d_par/load_valid/load_ready word handshake, shift_en bit advance,
//   d_out/out_valid serial stream, busy word in flight, done end-of-word pulse.
//   All outputs registered except load_ready.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    piso_shift_tx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sr_adv;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             load_ready;
    logic             accept;

    // The bit presented on d_out always sits at the leading end of sr.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign sr_adv = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sr_q[WIDTH-1:1]};

    // Last bit is being consumed this cycle; a new word may follow
    // with no gap.
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST)
                        && bus.shift_en;
    assign load_ready = (state_q == IDLE) || last_bit;
    assign accept     = bus.load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        d_out_d     = d_out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    sr_d        = bus.d_par;
                    cnt_d       = '0;
                    d_out_d     = lead_bit(bus.d_par);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_q == LAST) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (accept) begin
                            sr_d    = bus.d_par;
                            d_out_d = lead_bit(bus.d_par);
                        end else begin
                            state_d     = IDLE;
                            sr_d        = '0;
                            d_out_d     = 1'b0;
                            out_valid_d = 1'b0;
                            busy_d      = 1'b0;
                        end
                    end else begin
                        sr_d    = sr_adv;
                        cnt_d   = cnt_q + 1'b1;
                        d_out_d = lead_bit(sr_adv);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            d_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.d_out      = d_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: MSB-first and LSB-first instances,
// hand-computed serial sequences checked with immediate assertions.
module tb_piso_shift_tx;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    piso_shift_tx_if #(.WIDTH(4)) bus_m ();
    piso_shift_tx_if #(.WIDTH(4)) bus_l ();

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    // Rising edges at 10, 20, 30 ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // d_out, out_valid, busy, done of the MSB-first instance
    task automatic chk_m(input string tag, input logic d, input logic v,
                         input logic b, input logic dn);
        chk({tag, ".d_out"}, bus_m.d_out, d);
        chk({tag, ".out_valid"}, bus_m.out_valid, v);
        chk({tag, ".busy"}, bus_m.busy, b);
        chk({tag, ".done"}, bus_m.done, dn);
    endtask

    task automatic chk_l(input string tag, input logic d, input logic v,
                         input logic b, input logic dn);
        chk({tag, ".d_out"}, bus_l.d_out, d);
        chk({tag, ".out_valid"}, bus_l.out_valid, v);
        chk({tag, ".busy"}, bus_l.busy, b);
        chk({tag, ".done"}, bus_l.done, dn);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus_m.d_par      = 4'b0000;
        bus_m.load_valid = 1'b0;
        bus_m.shift_en   = 1'b1;
        bus_l.d_par      = 4'b0000;
        bus_l.load_valid = 1'b0;
        bus_l.shift_en   = 1'b1;

        // 1: reset
        #12;
        chk_m("rst_m", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_l("rst_l", 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("rel.load_ready", bus_m.load_ready, 1'b1);
        chk("rel.busy", bus_m.busy, 1'b0);

        // 2: 1011 MSB first
        bus_m.d_par      = 4'b1011;
        bus_m.load_valid = 1'b1;
        step();
        bus_m.load_valid = 1'b0;
        chk_m("t2.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2.lr_busy", bus_m.load_ready, 1'b0);
        step();
        chk_m("t2.b1", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t2.b2", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t2.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2.lr_last", bus_m.load_ready, 1'b1);
        step();
        chk_m("t2.end", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_m("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: same word, shift_en low for 2 cycles on bit 2
        bus_m.load_valid = 1'b1;
        step();
        bus_m.load_valid = 1'b0;
        chk_m("t3.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t3.b1", 1'b0, 1'b1, 1'b1, 1'b0);
        bus_m.shift_en = 1'b0;
        step();
        chk_m("t3.h1", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t3.h2", 1'b0, 1'b1, 1'b1, 1'b0);
        bus_m.shift_en = 1'b1;
        step();
        chk_m("t3.b2", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t3.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t3.end", 1'b0, 1'b0, 1'b0, 1'b1);

        // 4: back-to-back 1100 then 0011
        bus_m.d_par      = 4'b1100;
        bus_m.load_valid = 1'b1;
        step();
        bus_m.d_par = 4'b0011;
        chk_m("t4.a0", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t4.a1", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t4.a2", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t4.a3", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4.lr_last", bus_m.load_ready, 1'b1);
        step();
        bus_m.load_valid = 1'b0;
        chk_m("t4.b0", 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        chk_m("t4.b1", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t4.b2", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t4.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t4.end", 1'b0, 1'b0, 1'b0, 1'b1);

        // 5: reset mid-word of 1010, then 0110
        bus_m.d_par      = 4'b1010;
        bus_m.load_valid = 1'b1;
        step();
        bus_m.load_valid = 1'b0;
        chk_m("t5.a0", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t5.a1", 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk_m("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #5;
        reset = 1'b1;
        step();
        chk_m("t5.nodone", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_m("t5.nodone2", 1'b0, 1'b0, 1'b0, 1'b0);
        bus_m.d_par      = 4'b0110;
        bus_m.load_valid = 1'b1;
        step();
        bus_m.load_valid = 1'b0;
        chk_m("t5.b0", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t5.b1", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t5.b2", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t5.b3", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_m("t5.end", 1'b0, 1'b0, 1'b0, 1'b1);

        // 6: LSB first 0001, load of 1111 mid-word ignored
        bus_l.d_par      = 4'b0001;
        bus_l.load_valid = 1'b1;
        step();
        bus_l.d_par = 4'b1111;
        chk_l("t6.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6.lr_busy", bus_l.load_ready, 1'b0);
        step();
        chk_l("t6.b1", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_l("t6.b2", 1'b0, 1'b1, 1'b1, 1'b0);
        bus_l.load_valid = 1'b0;
        step();
        chk_l("t6.b3", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_l("t6.end", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_l("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
